ibex_to_wb_master: RTL and testbench
====================================

// Module: ibex_to_wb_master
//
// PURPOSE
//  Bridges an Ibex-style memory port (req/gnt/rvalid, core acts as initiator) onto a
//  Wishbone B4 pipelined master port.
//  - Drives the Wishbone signals cyc/stb/we/adr/sel/dat.
//  - Tracks up to MAX_OUTSTANDING accepted-but-unanswered transfers.
//  - Returns one in-order rvalid per granted request.
//  - A response watchdog aborts a hung bus cycle and answers all pending requests
//    with err.
//  Sits between the Ibex LSU/IF port and the system Wishbone interconnect.
//
// PARAMETERS
//  AW               32  address width
//  DW               32  data width; byte enables are DW/8
//  MAX_OUTSTANDING  2   max accepted transfers awaiting ack/err (>=1)
//  TIMEOUT          256 cycles without ack/err while pending before abort (>=2)
//
// PORTS
//  clk_i      in   1        clock, all state on rising edge
//  rst_ni     in   1        asynchronous active-low reset
//  req_i      in   1        Ibex request, held with addr/we/be/wdata until gnt_o
//  gnt_o      out  1        request accepted this cycle
//  we_i       in   1        1=write, 0=read
//  be_i       in   DW/8     byte enables
//  addr_i     in   AW       byte address
//  wdata_i    in   DW       write data
//  rvalid_o   out  1        response valid, one per granted request, in order
//  rdata_o    out  DW       read data, valid with rvalid_o
//  err_o      out  1        bus error / timeout, valid with rvalid_o
//  wb_cyc_o   out  1        Wishbone cycle
//  wb_stb_o   out  1        Wishbone strobe
//  wb_we_o    out  1        Wishbone write enable (=we_i)
//  wb_adr_o   out  AW       Wishbone address (=addr_i)
//  wb_sel_o   out  DW/8     Wishbone select (=be_i)
//  wb_dat_o   out  DW       Wishbone write data (=wdata_i)
//  wb_dat_i   in   DW       Wishbone read data
//  wb_ack_i   in   1        Wishbone ack
//  wb_err_i   in   1        Wishbone error
//  wb_stall_i in   1        Wishbone stall
//
// BEHAVIOUR
//  Reset values
//  - rst_ni low: FSM=IDLE, cnt=0, timer=0.
//  - rvalid_o, err_o and rdata_o are 0.
//  - gnt_o, wb_stb_o and wb_cyc_o are forced 0.
//
//  Acceptance and outstanding count
//  - room = (cnt < MAX_OUTSTANDING) & (state != ABORT).
//  - wb_stb_o = req_i & room.
//  - gnt_o = accept = wb_stb_o & ~wb_stall_i. This path is combinational, zero
//    added latency.
//  - resp = (wb_ack_i | wb_err_i) & (cnt != 0) & (state == ACTIVE).
//  - Any ack/err with cnt==0, or in IDLE/ABORT, is spurious and is ignored.
//  - An ack in the same cycle as an accept answers an older transfer only
//    (uses the registered cnt).
//  - cnt <= cnt + accept - resp. Simultaneous accept+resp leaves cnt unchanged.
//    cnt never exceeds MAX_OUTSTANDING and never underflows.
//  - wb_cyc_o = wb_stb_o | (state == ACTIVE). It drops in the first cycle where
//    cnt==0 and no request is issued.
//
//  Response path (registered, 1-cycle latency)
//  - The cycle after resp: rvalid_o=1, err_o=wb_err_i, rdata_o=wb_dat_i.
//  - On err, or on a write, rdata_o = 0.
//  - With no response, rvalid_o=0, err_o=0, rdata_o=0.
//  - If ack and err are both high, the transfer is treated as err.
//
//  FSM
//  - IDLE -> ACTIVE on accept.
//  - ACTIVE -> IDLE when next cnt==0.
//  - ACTIVE -> ABORT when timer reaches TIMEOUT-1.
//  - timer clears on resp or accept; it counts while cnt!=0 and no resp.
//  - ABORT: wb_cyc_o=0, no grants. Emits one rvalid_o with err_o=1 and rdata_o=0
//    per cycle, decrementing cnt each time. Bus acks are ignored.
//  - ABORT -> IDLE when cnt reaches 0.
//
//  Reset mid-operation
//  - All state clears immediately (asynchronous reset); pending transfers are
//    dropped with no response.
//  - The Ibex side is reset in the same domain.
//
// TESTING
//  1. Single read 0x100, stall=0, ack 1 cycle later, dat=0xDEADBEEF -> gnt in the
//     req cycle; rvalid=1, rdata=0xDEADBEEF, err=0 the cycle after ack; cyc then 0.
//  2. Write with stall=1 for 3 cycles -> stb=1 and adr/sel/dat stable, gnt=0 for
//     3 cycles; gnt=1 in cycle 4; one rvalid, err=0.
//  3. Three back-to-back reads, MAX_OUTSTANDING=2, acks delayed 3 cycles ->
//     3rd gnt withheld until the 1st ack; cnt never >2; rdata returned in order.
//  4. Two reads, wb_err on the 2nd -> rvalid pulses with err 0 then 1; rdata of
//     the 2nd = 0.
//  5. TIMEOUT=16, two accepted reads, no ack -> ABORT at cycle 16, cyc=0; two
//     consecutive rvalid with err=1; a late ack is ignored; back to IDLE.
//  6. rst_ni low mid-burst with cnt=2 -> all outputs 0 asynchronously; after
//     release, a new read completes normally and spurious acks are ignored.

Source files
------------

// File: rtl/ibex_to_wb_master.sv
// Ibex req/gnt/rvalid port to Wishbone B4 pipelined master; grant is combinational,
// responses return registered one cycle after ack/err, with a watchdog abort on a hung bus.
module ibex_to_wb_master #(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TIMEOUT         = 256
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          req_i,
  output logic          gnt_o,
  input  logic          we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          rvalid_o,
  output logic [DW-1:0] rdata_o,
  output logic          err_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic          wb_we_o,
  output logic [AW-1:0] wb_adr_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [DW-1:0] wb_dat_o,
  input  logic [DW-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_stall_i
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_ABORT  = 2'd2
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [CW-1:0]              r_cnt, w_cnt_nxt;
  logic [TW-1:0]              r_timer, w_timer_nxt;
  logic [MAX_OUTSTANDING-1:0] r_we_q, w_we_q_nxt;
  logic                       r_rvalid;
  logic                       r_err;
  logic [DW-1:0]              r_rdata;

  logic          w_room;
  logic          w_accept;
  logic          w_resp;
  logic          w_abort_rsp;
  logic          w_pop;
  logic [CW-1:0] w_wr_idx;

  // Reset gates the combinational request path so nothing leaks out while rst_ni is low.
  assign w_room      = rst_ni & (r_cnt < MAX_CNT) & (r_state != S_ABORT);
  assign wb_stb_o    = req_i & w_room;
  assign w_accept    = wb_stb_o & ~wb_stall_i;
  assign gnt_o       = w_accept;
  assign w_resp      = (wb_ack_i | wb_err_i) & (r_cnt != '0) & (r_state == S_ACTIVE);
  assign w_abort_rsp = (r_state == S_ABORT) & (r_cnt != '0);
  assign w_pop       = w_resp | w_abort_rsp;
  assign wb_cyc_o    = wb_stb_o | (r_state == S_ACTIVE);

  assign wb_we_o  = we_i;
  assign wb_adr_o = addr_i;
  assign wb_sel_o = be_i;
  assign wb_dat_o = wdata_i;

  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
  assign rdata_o  = r_rdata;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_accept && !w_pop) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (!w_accept && w_pop) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  // Per-transfer write flag, oldest at bit 0, so read data can be zeroed for writes.
  assign w_wr_idx = r_cnt - CW'(w_pop);

  always_comb begin
    w_we_q_nxt = r_we_q;
    if (w_pop) begin
      w_we_q_nxt = r_we_q >> 1;
    end
    if (w_accept) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (CW'(i) == w_wr_idx) begin
          w_we_q_nxt[i] = we_i;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (w_accept) begin
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_resp || w_accept) begin
          w_timer_nxt = '0;
        end else if (r_cnt != '0) begin
          w_timer_nxt = r_timer + 1'b1;
        end
        if (w_cnt_nxt == '0) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
        end else if (r_timer == TIMER_MAX && !w_resp && !w_accept) begin
          w_state_nxt = S_ABORT;
          w_timer_nxt = '0;
        end
      end
      S_ABORT: begin
        w_timer_nxt = '0;
        if (w_cnt_nxt == '0) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_timer  <= '0;
      r_we_q   <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_timer  <= w_timer_nxt;
      r_we_q   <= w_we_q_nxt;
      r_rvalid <= w_pop;
      r_err    <= w_abort_rsp | (w_resp & wb_err_i);
      r_rdata  <= (w_resp && !wb_err_i && !r_we_q[0]) ? wb_dat_i : '0;
    end
  end

endmodule

// File: tb/tb_ibex_to_wb_master.sv
// Directed bench for ibex_to_wb_master (MAX_OUTSTANDING=2, TIMEOUT=16).
module tb_ibex_to_wb_master;

  logic        clk_i;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_stall_i;

  int n_tests = 0;
  int n_fail  = 0;

  ibex_to_wb_master #(
    .AW(32), .DW(32), .MAX_OUTSTANDING(2), .TIMEOUT(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req_i), .gnt_o(gnt_o), .we_i(we_i), .be_i(be_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_stall_i(wb_stall_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wdata, input logic stall,
                       input logic ack, input logic err, input logic [31:0] dat);
    req_i = req; we_i = we; addr_i = addr; be_i = be; wdata_i = wdata;
    wb_stall_i = stall; wb_ack_i = ack; wb_err_i = err; wb_dat_i = dat;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a pending request: all outputs must stay low.
    rst_ni = 1'b0;
    drive(1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h1);
    #2;
    check("rst_gnt", gnt_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_rvalid", rvalid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_rdata", rdata_o, 0);
    nxt(); rst_ni = 1'b1; idle(); #1;
    check("rst_rel_cyc", wb_cyc_o, 0);

    // 1: single read
    nxt(); drive(1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t1_gnt", gnt_o, 1);
    check("t1_stb", wb_stb_o, 1);
    check("t1_cyc", wb_cyc_o, 1);
    check("t1_adr", wb_adr_o, 32'h100);
    check("t1_we", wb_we_o, 0);
    nxt(); drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF); #1;
    check("t1_gnt_off", gnt_o, 0);
    check("t1_cyc_hold", wb_cyc_o, 1);
    check("t1_rvalid_early", rvalid_o, 0);
    nxt(); idle(); #1;
    check("t1_rvalid", rvalid_o, 1);
    check("t1_rdata", rdata_o, 32'hDEADBEEF);
    check("t1_err", err_o, 0);
    check("t1_cyc_drop", wb_cyc_o, 0);
    nxt(); #1;
    check("t1_rvalid_off", rvalid_o, 0);

    // 2: stalled write
    for (int k = 0; k < 3; k++) begin
      nxt(); drive(1'b1, 1'b1, 32'h200, 4'h3, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h0); #1;
      check("t2_stall_stb", wb_stb_o, 1);
      check("t2_stall_gnt", gnt_o, 0);
      check("t2_stall_adr", wb_adr_o, 32'h200);
      check("t2_stall_sel", wb_sel_o, 4'h3);
      check("t2_stall_dat", wb_dat_o, 32'h12345678);
      check("t2_stall_we", wb_we_o, 1);
    end
    nxt(); drive(1'b1, 1'b1, 32'h200, 4'h3, 32'h12345678, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t2_gnt", gnt_o, 1);
    nxt(); drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hFFFFFFFF); #1;
    check("t2_rvalid_early", rvalid_o, 0);
    nxt(); idle(); #1;
    check("t2_rvalid", rvalid_o, 1);
    check("t2_err", err_o, 0);
    check("t2_rdata_write", rdata_o, 0);
    nxt(); #1;
    check("t2_rvalid_off", rvalid_o, 0);
    check("t2_cyc_off", wb_cyc_o, 0);

    // 3: three reads against a limit of two outstanding
    nxt(); drive(1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t3_gnt1", gnt_o, 1);
    nxt(); drive(1'b1, 1'b0, 32'h304, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t3_gnt2", gnt_o, 1);
    nxt(); drive(1'b1, 1'b0, 32'h308, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t3_gnt3_held", gnt_o, 0);
    check("t3_stb_held", wb_stb_o, 0);
    check("t3_cyc", wb_cyc_o, 1);
    nxt(); drive(1'b1, 1'b0, 32'h308, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA1); #1;
    check("t3_gnt3_ack_cycle", gnt_o, 0);
    nxt(); drive(1'b1, 1'b0, 32'h308, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t3_gnt3", gnt_o, 1);
    check("t3_rvalid1", rvalid_o, 1);
    check("t3_rdata1", rdata_o, 32'hA1);
    nxt(); drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA2); #1;
    check("t3_rvalid_gap", rvalid_o, 0);
    nxt(); drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hA3); #1;
    check("t3_rvalid2", rvalid_o, 1);
    check("t3_rdata2", rdata_o, 32'hA2);
    nxt(); idle(); #1;
    check("t3_rvalid3", rvalid_o, 1);
    check("t3_rdata3", rdata_o, 32'hA3);
    check("t3_cyc_drop", wb_cyc_o, 0);
    nxt(); #1;
    check("t3_rvalid_off", rvalid_o, 0);

    // 4: bus error on the second read
    nxt(); drive(1'b1, 1'b0, 32'h400, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t4_gnt1", gnt_o, 1);
    nxt(); drive(1'b1, 1'b0, 32'h404, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t4_gnt2", gnt_o, 1);
    nxt(); drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hB1); #1;
    nxt(); drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 1'b1, 32'hBAD); #1;
    check("t4_rvalid1", rvalid_o, 1);
    check("t4_err1", err_o, 0);
    check("t4_rdata1", rdata_o, 32'hB1);
    nxt(); idle(); #1;
    check("t4_rvalid2", rvalid_o, 1);
    check("t4_err2", err_o, 1);
    check("t4_rdata2", rdata_o, 0);
    nxt(); #1;
    check("t4_rvalid_off", rvalid_o, 0);
    check("t4_cyc_off", wb_cyc_o, 0);

    // 5: watchdog abort with two pending reads
    nxt(); drive(1'b1, 1'b0, 32'h500, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t5_gnt1", gnt_o, 1);
    nxt(); drive(1'b1, 1'b0, 32'h504, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t5_gnt2", gnt_o, 1);
    for (int j = 1; j <= 16; j++) begin
      nxt(); idle(); #1;
      check("t5_wait_cyc", wb_cyc_o, 1);
      check("t5_wait_rvalid", rvalid_o, 0);
    end
    nxt(); drive(1'b1, 1'b0, 32'h508, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t5_abort_cyc", wb_cyc_o, 0);
    check("t5_abort_gnt", gnt_o, 0);
    check("t5_abort_stb", wb_stb_o, 0);
    check("t5_abort_rvalid_early", rvalid_o, 0);
    nxt(); drive(1'b1, 1'b0, 32'h508, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h55); #1;
    check("t5_rvalid1", rvalid_o, 1);
    check("t5_err1", err_o, 1);
    check("t5_rdata1", rdata_o, 0);
    check("t5_abort_gnt2", gnt_o, 0);
    nxt(); drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h66); #1;
    check("t5_rvalid2", rvalid_o, 1);
    check("t5_err2", err_o, 1);
    check("t5_rdata2", rdata_o, 0);
    nxt(); idle(); #1;
    check("t5_late_ack_ignored", rvalid_o, 0);
    check("t5_idle_cyc", wb_cyc_o, 0);

    // 6: reset in the middle of a burst
    nxt(); drive(1'b1, 1'b0, 32'h600, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t6_gnt1", gnt_o, 1);
    nxt(); drive(1'b1, 1'b0, 32'h604, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t6_gnt2", gnt_o, 1);
    nxt(); drive(1'b1, 1'b0, 32'h608, 4'hF, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); #1;
    check("t6_full_gnt", gnt_o, 0);
    check("t6_full_cyc", wb_cyc_o, 1);
    rst_ni = 1'b0; #1;
    check("t6_rst_gnt", gnt_o, 0);
    check("t6_rst_stb", wb_stb_o, 0);
    check("t6_rst_cyc", wb_cyc_o, 0);
    check("t6_rst_rvalid", rvalid_o, 0);
    nxt(); idle(); #1;
    check("t6_rst_hold_cyc", wb_cyc_o, 0);
    nxt(); rst_ni = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h77); #1;
    check("t6_rel_cyc", wb_cyc_o, 0);
    nxt(); drive(1'b1, 1'b0, 32'h700, 4'hF, 32'h0, 1'b0, 1'b1, 1'b0, 32'h88); #1;
    check("t6_spurious_rvalid", rvalid_o, 0);
    check("t6_new_gnt", gnt_o, 1);
    nxt(); idle(); #1;
    check("t6_spurious_rvalid2", rvalid_o, 0);
    check("t6_new_cyc", wb_cyc_o, 1);
    nxt(); drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b0, 32'hCAFEF00D); #1;
    nxt(); idle(); #1;
    check("t6_rvalid", rvalid_o, 1);
    check("t6_rdata", rdata_o, 32'hCAFEF00D);
    check("t6_err", err_o, 0);
    nxt(); #1;
    check("t6_rvalid_off", rvalid_o, 0);
    check("t6_cyc_off", wb_cyc_o, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
